lock_controller: RTL

Top-level sequencer for the keypad lock. Owns the password register file and the entry buffer. Drives the full flow: first-time password setup, armed entry, comparison, timed unlock, and retry lockout. Sits between the keypad debounce/decode logic and the lock actuator/status LEDs.

---
 rtl/lock_pkg.sv | 20 ++
 rtl/lock_controller_pw_store.sv | 47 ++++
 rtl/lock_controller.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock controller.
package lock_pkg;

  localparam int unsigned DEFAULT_SYM_W = 2;

  typedef enum logic [2:0] {
    StUnset   = 3'd0,
    StSetup   = 3'd1,
    StArmed   = 3'd2,
    StCheck   = 3'd3,
    StOpen    = 3'd4,
    StLockout = 3'd5
  } lock_state_t;

  // Bits needed for a counter that must hold the value n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_controller_pw_store.sv
// Password register file and stored length, with a combinational compare against an entry buffer.
module pw_store
  import lock_pkg::*;
#(
  parameter int unsigned SYM_W   = DEFAULT_SYM_W,
  parameter int unsigned MAX_LEN = 4,
  parameter int unsigned IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  parameter int unsigned LW      = cnt_w(MAX_LEN)
) (
  input  logic                            clk,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [IW-1:0]                   wr_idx,
  input  logic [SYM_W-1:0]                wr_data,
  input  logic                            commit,
  input  logic [LW-1:0]                   commit_len,
  input  logic [MAX_LEN-1:0][SYM_W-1:0]   entry,
  input  logic [LW-1:0]                   entry_len,
  output logic                            pw_valid,
  output logic                            match
);

  logic [MAX_LEN-1:0][SYM_W-1:0] pw;
  logic [LW-1:0]                 len;

  always_ff @(posedge clk) begin
    if (clear) begin
      pw       <= '0;
      len      <= '0;
      pw_valid <= 1'b0;
    end else begin
      if (wr_en) pw[wr_idx] <= wr_data;
      if (commit) begin
        len      <= commit_len;
        pw_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    match = pw_valid && (entry_len == len);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len) && (entry[i] != pw[i])) match = 1'b0;
    end
  end

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: password setup, armed entry, compare, timed unlock and retry lockout.
module lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned SYM_W          = DEFAULT_SYM_W,
  parameter int unsigned MAX_LEN        = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           key_valid,
  input  logic [SYM_W-1:0]               key_bits,
  input  logic                           key_enter,
  input  logic                           key_setup,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           setup_active,
  output logic                           pw_valid,
  output logic [$clog2(MAX_LEN+1)-1:0]   entry_len,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

  localparam int unsigned LW = cnt_w(MAX_LEN);
  localparam int unsigned FW = cnt_w(MAX_TRIES);
  localparam int unsigned TW =
      cnt_w((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  lock_state_t                   state, state_next;
  logic [LW-1:0]                 len_next;
  logic [FW-1:0]                 fail_next;
  logic [TW-1:0]                 timer, timer_next;
  logic [MAX_LEN-1:0][SYM_W-1:0] entry_buf;
  logic                          pw_we, pw_commit, ent_we, match, has_room;
  logic [IW-1:0]                 idx;

  assign idx      = entry_len[IW-1:0];
  assign has_room = entry_len < LW'(MAX_LEN);

  pw_store #(
    .SYM_W  (SYM_W),
    .MAX_LEN(MAX_LEN),
    .IW     (IW),
    .LW     (LW)
  ) u_pw_store (
    .clk       (clk),
    .clear     (!resetn),
    .wr_en     (pw_we),
    .wr_idx    (idx),
    .wr_data   (key_bits),
    .commit    (pw_commit),
    .commit_len(entry_len),
    .entry     (entry_buf),
    .entry_len (entry_len),
    .pw_valid  (pw_valid),
    .match     (match)
  );

  always_comb begin
    state_next = state;
    len_next   = entry_len;
    fail_next  = fail_count;
    timer_next = timer;
    pw_we      = 1'b0;
    pw_commit  = 1'b0;
    ent_we     = 1'b0;
    unique case (state)
      StUnset: begin
        if (key_setup) begin
          state_next = StSetup;
          len_next   = '0;
        end
      end
      StSetup: begin
        // key_enter wins over a same-cycle symbol, even when the enter itself is ignored.
        if (key_enter) begin
          if (entry_len != '0) begin
            pw_commit  = 1'b1;
            len_next   = '0;
            state_next = StArmed;
          end
        end else if (key_valid && has_room) begin
          pw_we    = 1'b1;
          len_next = entry_len + 1'b1;
        end
      end
      StArmed: begin
        if (key_enter) begin
          state_next = StCheck;
        end else if (key_valid && has_room) begin
          ent_we   = 1'b1;
          len_next = entry_len + 1'b1;
        end
      end
      StCheck: begin
        len_next = '0;
        if (match) begin
          fail_next  = '0;
          timer_next = TW'(OPEN_CYCLES);
          state_next = StOpen;
        end else begin
          fail_next = fail_count + 1'b1;
          if (fail_count + 1'b1 == FW'(MAX_TRIES)) begin
            timer_next = TW'(LOCKOUT_CYCLES);
            state_next = StLockout;
          end else begin
            state_next = StArmed;
          end
        end
      end
      StOpen: begin
        if (key_setup) begin
          len_next   = '0;
          state_next = StSetup;
        end else if (key_enter || timer == TW'(1)) begin
          state_next = StArmed;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      StLockout: begin
        if (timer == TW'(1)) begin
          fail_next  = '0;
          state_next = StArmed;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: state_next = StUnset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= StUnset;
      entry_len  <= '0;
      fail_count <= '0;
      timer      <= '0;
      entry_buf  <= '0;
    end else begin
      state      <= state_next;
      entry_len  <= len_next;
      fail_count <= fail_next;
      timer      <= timer_next;
      if (ent_we) entry_buf[idx] <= key_bits;
    end
  end

  assign unlocked     = (state == StOpen);
  assign locked_out   = (state == StLockout);
  assign setup_active = (state == StSetup);

endmodule
